// File: rtl/cpu_regs_pkg.sv
// Shared register-file constants, operand mask layout and operand-reader state encoding.
package cpu_regs_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned PC_IDX    = 15;
    localparam int unsigned PC_OFFSET = 8;

    localparam int unsigned OPB_RN = 0;
    localparam int unsigned OPB_RM = 1;
    localparam int unsigned OPB_RS = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StCapt,
        StDone
    } rd_state_e;

    // One-hot of the lowest set operand-enable bit (zero if none).
    function automatic logic [2:0] lowest_bit(input logic [2:0] m);
        return m & (~m + 3'd1);
    endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Capture-cycle operand select: PC substitute, live writeback, pending bypass, then bank data.
module regfile_bypass_mux
    import cpu_regs_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = cpu_regs_pkg::ADDR_W,
    parameter int unsigned PC_IDX    = cpu_regs_pkg::PC_IDX,
    parameter int unsigned PC_OFFSET = cpu_regs_pkg::PC_OFFSET
) (
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              byp_valid_i,
    input  logic [DATA_W-1:0] byp_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] operand_o
);

    localparam logic [ADDR_W-1:0] PcIdx = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PcOff = DATA_W'(PC_OFFSET);

    always_comb begin
        operand_o = rd_data_i;
        if (idx_i == PcIdx) begin
            operand_o = pc_i + PcOff;
        end else if (wb_en_i && (wb_addr_i == idx_i)) begin
            operand_o = wb_data_i;
        end else if (byp_valid_i) begin
            operand_o = byp_data_i;
        end
    end

endmodule

// File: rtl/regfile_operand_reader.sv
// Sequential Rn/Rm/Rs operand fetch over one synchronous bank read port, with PC
// substitution and writeback bypass, handing operands to execute via valid/ready.
module regfile_operand_reader
    import cpu_regs_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = cpu_regs_pkg::ADDR_W,
    parameter int unsigned PC_IDX    = cpu_regs_pkg::PC_IDX,
    parameter int unsigned PC_OFFSET = cpu_regs_pkg::PC_OFFSET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rn,
    input  logic [ADDR_W-1:0] req_rm,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [2:0]        req_mask,
    input  logic [DATA_W-1:0] req_pc,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_rn,
    output logic [DATA_W-1:0] op_rm,
    output logic [DATA_W-1:0] op_rs
);

    localparam logic [ADDR_W-1:0] PcIdx = ADDR_W'(PC_IDX);

    rd_state_e         state_q, state_d;
    logic [2:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              byp_valid_q, byp_valid_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [DATA_W-1:0] op_rn_q, op_rn_d, op_rm_q, op_rm_d, op_rs_q, op_rs_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic [2:0]        sel_oh, mask_clr;
    logic [ADDR_W-1:0] sel_idx, iss_idx;
    logic [DATA_W-1:0] capt_val;

    function automatic logic [ADDR_W-1:0] pick_idx(input logic [2:0] oh,
                                                   input logic [ADDR_W-1:0] rn,
                                                   input logic [ADDR_W-1:0] rm,
                                                   input logic [ADDR_W-1:0] rs);
        if (oh[OPB_RN]) return rn;
        if (oh[OPB_RM]) return rm;
        return rs;
    endfunction

    assign sel_oh   = lowest_bit(mask_q);
    assign sel_idx  = pick_idx(sel_oh, rn_q, rm_q, rs_q);
    assign mask_clr = mask_q & ~sel_oh;

    regfile_bypass_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_IDX   (PC_IDX),
        .PC_OFFSET(PC_OFFSET)
    ) u_bypass_mux (
        .idx_i      (sel_idx),
        .pc_i       (pc_q),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .byp_valid_i(byp_valid_q),
        .byp_data_i (byp_data_q),
        .rd_data_i  (rf_rd_data),
        .operand_o  (capt_val)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        rs_d        = rs_q;
        pc_d        = pc_q;
        byp_valid_d = byp_valid_q;
        byp_data_d  = byp_data_q;
        op_rn_d     = op_rn_q;
        op_rm_d     = op_rm_q;
        op_rs_d     = op_rs_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        iss_idx     = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rn_d        = req_rn;
                    rm_d        = req_rm;
                    rs_d        = req_rs;
                    mask_d      = req_mask;
                    pc_d        = req_pc;
                    op_rn_d     = '0;
                    op_rm_d     = '0;
                    op_rs_d     = '0;
                    byp_valid_d = 1'b0;
                    if (req_mask == 3'b000) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRead;
                        iss_idx   = pick_idx(lowest_bit(req_mask), req_rn, req_rm, req_rs);
                        rd_en_d   = (iss_idx != PcIdx);
                        rd_addr_d = rd_en_d ? iss_idx : '0;
                    end
                end
            end
            StRead: begin
                // Bank returns old data on read-during-write, so hold the new value aside.
                if (wb_en && (wb_addr == sel_idx) && (sel_idx != PcIdx)) begin
                    byp_valid_d = 1'b1;
                    byp_data_d  = wb_data;
                end
                state_d = StCapt;
            end
            StCapt: begin
                if (sel_oh[OPB_RN]) op_rn_d = capt_val;
                if (sel_oh[OPB_RM]) op_rm_d = capt_val;
                if (sel_oh[OPB_RS]) op_rs_d = capt_val;
                mask_d      = mask_clr;
                byp_valid_d = 1'b0;
                if (mask_clr != 3'b000) begin
                    state_d   = StRead;
                    iss_idx   = pick_idx(lowest_bit(mask_clr), rn_q, rm_q, rs_q);
                    rd_en_d   = (iss_idx != PcIdx);
                    rd_addr_d = rd_en_d ? iss_idx : '0;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (op_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            rs_q        <= '0;
            pc_q        <= '0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
            op_rn_q     <= '0;
            op_rm_q     <= '0;
            op_rs_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            rs_q        <= rs_d;
            pc_q        <= pc_d;
            byp_valid_q <= byp_valid_d;
            byp_data_q  <= byp_data_d;
            op_rn_q     <= op_rn_d;
            op_rm_q     <= op_rm_d;
            op_rs_q     <= op_rs_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign op_valid   = (state_q == StDone);
    assign rf_rd_en   = rd_en_q;
    assign rf_rd_addr = rd_addr_q;
    assign op_rn      = op_rn_q;
    assign op_rm      = op_rm_q;
    assign op_rs      = op_rs_q;

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Directed bench for regfile_operand_reader with a behavioural register bank.
module tb_regfile_operand_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_rn, req_rm, req_rs;
    logic [2:0]  req_mask;
    logic [31:0] req_pc;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rn, op_rm, op_rs;

    logic        bank_init;
    logic [31:0] bank [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_operand_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_rs    (req_rs),
        .req_mask  (req_mask),
        .req_pc    (req_pc),
        .rf_rd_en  (rf_rd_en),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_rn     (op_rn),
        .op_rm     (op_rm),
        .op_rs     (op_rs)
    );

    // Synchronous-read bank: read-during-write returns the old contents.
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 16; i++) bank[i] <= 32'h11 * i;
            bank[4] <= 32'h0000AAAA;
            rf_rd_data <= 32'h0;
        end else begin
            if (rf_rd_en) rf_rd_data <= bank[rf_rd_addr];
            if (wb_en) bank[wb_addr] <= wb_data;
        end
    end

    typedef struct {
        logic [2:0]  mask;
        logic [3:0]  rn, rm, rs;
        logic [31:0] pc;
        int          wb_cyc;
        logic [31:0] wb_data;
        logic [31:0] e_rn, e_rm, e_rs;
        int          e_lat;
        int          e_rdn;
        logic [11:0] e_addrs;
        int          hold;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          lat;
        int          rdn;
        logic [11:0] addrs;
        @(negedge clk);
        bank_init = 1'b1;
        @(negedge clk);
        bank_init = 1'b0;
        chk($sformatf("v%0d req_ready_idle", id), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_mask  = v.mask;
        req_rn    = v.rn;
        req_rm    = v.rm;
        req_rs    = v.rs;
        req_pc    = v.pc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat   = -1;
        rdn   = 0;
        addrs = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            wb_en   = (n == v.wb_cyc);
            wb_addr = 4'd4;
            wb_data = v.wb_data;
            if (rf_rd_en) begin
                if (rdn < 3) addrs = addrs | (12'(rf_rd_addr) << (4 * rdn));
                rdn++;
            end
            if (op_valid) begin
                lat = n;
                break;
            end
        end
        wb_en = 1'b0;
        chk($sformatf("v%0d latency", id), lat, v.e_lat);
        chk($sformatf("v%0d rd_count", id), rdn, v.e_rdn);
        chk($sformatf("v%0d rd_addrs", id), {20'b0, addrs}, {20'b0, v.e_addrs});
        chk($sformatf("v%0d op_rn", id), op_rn, v.e_rn);
        chk($sformatf("v%0d op_rm", id), op_rm, v.e_rm);
        chk($sformatf("v%0d op_rs", id), op_rs, v.e_rs);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold%0d valid_ready_rd", id, h),
                {29'b0, op_valid, req_ready, rf_rd_en}, 32'b100);
            chk($sformatf("v%0d hold%0d ops", id, h), op_rn ^ op_rm ^ op_rs,
                v.e_rn ^ v.e_rm ^ v.e_rs);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk($sformatf("v%0d release", id), {30'b0, op_valid, req_ready}, 32'b01);
    endtask

    initial begin
        vecs[0] = '{3'b111, 4'd1, 4'd2, 4'd3, 32'h0, 0, 32'h0,
                    32'h11, 32'h22, 32'h33, 7, 3, 12'h321, 2};
        vecs[1] = '{3'b001, 4'd15, 4'd0, 4'd0, 32'h00001000, 0, 32'h0,
                    32'h00001008, 32'h0, 32'h0, 3, 0, 12'h000, 1};
        vecs[2] = '{3'b010, 4'd0, 4'd4, 4'd0, 32'h0, 1, 32'hBEEF,
                    32'h0, 32'hBEEF, 32'h0, 3, 1, 12'h004, 1};
        vecs[3] = '{3'b010, 4'd0, 4'd4, 4'd0, 32'h0, 2, 32'hBEEF,
                    32'h0, 32'hBEEF, 32'h0, 3, 1, 12'h004, 1};
        vecs[4] = '{3'b000, 4'd1, 4'd2, 4'd3, 32'h0, 0, 32'h0,
                    32'h0, 32'h0, 32'h0, 1, 0, 12'h000, 5};
        vecs[5] = '{3'b100, 4'd0, 4'd0, 4'd15, 32'hFFFFFFFC, 0, 32'h0,
                    32'h0, 32'h0, 32'h00000004, 3, 0, 12'h000, 1};
        vecs[6] = '{3'b011, 4'd5, 4'd5, 4'd9, 32'h0, 0, 32'h0,
                    32'h55, 32'h55, 32'h0, 5, 2, 12'h055, 1};
        vecs[7] = '{3'b111, 4'd15, 4'd2, 4'd15, 32'h00000100, 0, 32'h0,
                    32'h108, 32'h22, 32'h108, 7, 1, 12'h002, 1};

        reset     = 1'b1;
        bank_init = 1'b1;
        req_valid = 1'b0;
        req_rn    = '0;
        req_rm    = '0;
        req_rs    = '0;
        req_mask  = '0;
        req_pc    = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        op_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready_valid_rd", {29'b0, req_ready, op_valid, rf_rd_en}, 32'b100);
        chk("rst rd_addr", {28'b0, rf_rd_addr}, 32'd0);
        chk("rst ops", op_rn | op_rm | op_rs, 32'd0);
        reset     = 1'b0;
        bank_init = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during the second READ of a three-operand fetch.
        @(negedge clk);
        req_valid = 1'b1;
        req_mask  = 3'b111;
        req_rn    = 4'd1;
        req_rm    = 4'd2;
        req_rs    = 4'd3;
        req_pc    = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid second_read_rd", {27'b0, rf_rd_en, rf_rd_addr}, {27'b0, 1'b1, 4'd2});
        chk("mid partial_rn", op_rn, 32'h11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready_valid", {30'b0, req_ready, op_valid}, 32'b10);
        chk("abort ops", op_rn | op_rm | op_rs, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort no_rd%0d", c), {31'b0, rf_rd_en}, 32'd0);
        end

        run_vec(vecs[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
